// File: rtl/alu_issue_pkg.sv
// Shared opcode, flag and pending-tracker definitions for the ALU issue stage.
// Imported by the issue stage top level and its register file.
package alu_issue_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_LD  = 5'h01;
    localparam logic [4:0] OP_ADD = 5'h03;
    localparam logic [4:0] OP_SUB = 5'h04;
    localparam logic [4:0] OP_AND = 5'h05;
    localparam logic [4:0] OP_OR  = 5'h06;
    localparam logic [4:0] OP_XOR = 5'h07;
    localparam logic [4:0] OP_NOT = 5'h08;
    localparam logic [4:0] OP_SL  = 5'h09;
    localparam logic [4:0] OP_SR  = 5'h0A;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
    } pend_t;

    function automatic logic is_alu_op(input logic [4:0] op);
        case (op)
            OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_SL, OP_SR: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SL, OP_SR: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// 2-read/1-write register file; r0 is hardwired to zero and reads see a
// same-cycle write (write-through bypass).
module alu_regfile
    import alu_issue_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   raddr_a_i,
    input  logic [AW-1:0]   raddr_b_i,
    output logic [XLEN-1:0] rdata_a_o,
    output logic [XLEN-1:0] rdata_b_o,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && waddr_i != '0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = regs_q[raddr_a_i];
        if (raddr_a_i == '0) begin
            rdata_a_o = '0;
        end else if (we_i && waddr_i == raddr_a_i) begin
            rdata_a_o = wdata_i;
        end
    end

    always_comb begin
        rdata_b_o = regs_q[raddr_b_i];
        if (raddr_b_i == '0) begin
            rdata_b_o = '0;
        end else if (we_i && waddr_i == raddr_b_i) begin
            rdata_b_o = wdata_i;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue stage in front of the ALU: RAW hazard stall, operand
// launch, result writeback after ALU_LAT cycles and status flag capture.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [AW-1:0]   in_rd,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic            in_use_imm,
    input  logic [XLEN-1:0] in_imm,
    output logic [XLEN-1:0] busA,
    output logic [XLEN-1:0] busB,
    output logic [4:0]      operation,
    input  logic [XLEN-1:0] result,
    input  logic            z,
    input  logic            n,
    input  logic            c,
    input  logic            v,
    output logic            wb_valid,
    output logic [AW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [3:0]      flags
);

    logic [XLEN-1:0] rdata_a, rdata_b;
    logic [XLEN-1:0] busA_q, busA_d, busB_q, busB_d;
    logic [4:0]      operation_q, operation_d;
    logic            wb_valid_q;
    logic [AW-1:0]   wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic [3:0]      flags_q;
    pend_t           pend_q [ALU_LAT+1];
    pend_t           pend_d, wb_ent;
    logic            use_a, use_b, hazard, accept, rf_we;

    assign wb_ent = pend_q[ALU_LAT];
    assign rf_we  = wb_ent.valid && wb_ent.rd != '0;

    alu_regfile #(.NREGS(NREGS)) u_rf (
        .clk_i     (clk),
        .rst_i     (rst),
        .raddr_a_i (in_rs1),
        .raddr_b_i (in_rs2),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b),
        .we_i      (rf_we),
        .waddr_i   (wb_ent.rd),
        .wdata_i   (result)
    );

    // An op stays in the tracker until its writeback edge, so a dependent
    // op issues one cycle after the producer has reached the register file.
    always_comb begin
        use_a  = is_alu_op(in_op) && !(in_use_imm && in_op == OP_LD);
        use_b  = uses_rs2(in_op) && !in_use_imm;
        hazard = 1'b0;
        for (int i = 0; i <= ALU_LAT; i++) begin
            if (pend_q[i].valid && pend_q[i].rd != '0) begin
                if (use_a && in_rs1 == pend_q[i].rd) hazard = 1'b1;
                if (use_b && in_rs2 == pend_q[i].rd) hazard = 1'b1;
            end
        end
    end

    assign in_ready = !rst && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        busA_d      = busA_q;
        busB_d      = busB_q;
        operation_d = OP_NOP;
        pend_d      = '0;
        if (accept) begin
            busA_d      = (in_use_imm && in_op == OP_LD) ? in_imm : rdata_a;
            busB_d      = (in_use_imm && in_op != OP_LD) ? in_imm : rdata_b;
            operation_d = in_op;
            pend_d      = '{valid: is_alu_op(in_op), rd: in_rd};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busA_q      <= '0;
            busB_q      <= '0;
            operation_q <= OP_NOP;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            flags_q     <= '0;
            for (int i = 0; i <= ALU_LAT; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            busA_q      <= busA_d;
            busB_q      <= busB_d;
            operation_q <= operation_d;
            pend_q[0]   <= pend_d;
            for (int i = 1; i <= ALU_LAT; i++) begin
                pend_q[i] <= pend_q[i-1];
            end
            wb_valid_q <= rf_we;
            if (rf_we) begin
                wb_rd_q   <= wb_ent.rd;
                wb_data_q <= result;
            end
            if (wb_ent.valid) begin
                flags_q[FLAG_Z] <= z;
                flags_q[FLAG_N] <= n;
                flags_q[FLAG_C] <= c;
                flags_q[FLAG_V] <= v;
            end
        end
    end

    assign busA      = busA_q;
    assign busB      = busB_q;
    assign operation = operation_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a one-cycle ALU stand-in and
// hand-computed expected writebacks, flags and issue spacing.
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic        in_use_imm = 1'b0;
    logic [31:0] in_imm = '0;
    logic [31:0] busA, busB, result;
    logic [4:0]  operation;
    logic        z, n, c, v;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } wb_ev_t;
    wb_ev_t wb_log[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_stage #(.NREGS(32), .ALU_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .busA       (busA),
        .busB       (busB),
        .operation  (operation),
        .result     (result),
        .z          (z),
        .n          (n),
        .c          (c),
        .v          (v),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .flags      (flags)
    );

    // ALU stand-in: {z,n,c,v,result}, one register stage
    function automatic logic [35:0] alu_f(input logic [4:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        cf, vf;
        r  = '0;
        cf = 1'b0;
        vf = 1'b0;
        case (op)
            OP_LD:  r = a;
            OP_ADD: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                cf = s[32];
                vf = (a[31] == b[31]) && (r[31] != a[31]);
            end
            OP_SUB: begin
                r  = a - b;
                cf = (a < b);
                vf = (a[31] != b[31]) && (r[31] != a[31]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_SL:  r = a << b[4:0];
            OP_SR:  r = a >> b[4:0];
            default: r = '0;
        endcase
        return {(r == 32'd0), r[31], cf, vf, r};
    endfunction

    logic [35:0] alu_q = '0;
    always @(posedge clk) alu_q <= alu_f(operation, busA, busB);
    assign result       = alu_q[31:0];
    assign {z, n, c, v} = alu_q[35:32];

    always @(negedge clk) begin
        if (wb_valid) wb_log.push_back('{wb_rd, wb_data, cyc});
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int nc);
        repeat (nc) @(posedge clk);
        #1;
    endtask

    // Presents one op from posedge+1, holds it until accepted and returns
    // at posedge+1 after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic ui, input logic [31:0] imm,
                         output int acc);
        int waited;
        in_valid   = 1'b1;
        in_op      = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_imm = ui;
        in_imm     = imm;
        waited     = 0;
        #1;
        while (!in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 20) check("issue_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic expect_wb(input string tag, input logic [4:0] rd,
                             input logic [31:0] exp);
        logic [31:0] g;
        g = 'x;
        foreach (wb_log[i]) begin
            if (wb_log[i].rd == rd) g = wb_log[i].data;
        end
        check(tag, g, exp);
    endtask

    typedef struct {
        logic [4:0]  op, rd, rs1, rs2;
        logic        ui;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t stream[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, a1;
        int acc[8];

        // reset state
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_busA", busA, 0);
        check("rst_op", operation, 0);
        check("rst_flags", flags, 0);
        check("rst_wbv", wb_valid, 0);
        tick(2);
        rst = 1'b0;
        #1;
        check("rel_ready", in_ready, 1);
        tick(1);

        // 1: LD immediate
        issue(OP_LD, 5'd1, 5'd0, 5'd0, 1'b1, 32'h0F0F0F0F, a0);
        check("t1_busA", busA, 32'h0F0F0F0F);
        check("t1_op", operation, 32'h1);
        check("t1_wbv_e1", wb_valid, 0);
        tick(1);
        check("t1_op_nop", operation, 0);
        check("t1_wbv_e2", wb_valid, 0);
        tick(1);
        check("t1_wbv", wb_valid, 1);
        check("t1_wbrd", wb_rd, 1);
        check("t1_wbdata", wb_data, 32'h0F0F0F0F);
        tick(1);
        check("t1_wbv_off", wb_valid, 0);
        check("t1_flags", flags, 4'h0);

        // 2: ADD overflow
        issue(OP_LD, 5'd2, 5'd0, 5'd0, 1'b1, 32'h7FFFFFFF, a0);
        issue(OP_LD, 5'd3, 5'd0, 5'd0, 1'b1, 32'h00000001, a0);
        issue(OP_ADD, 5'd4, 5'd2, 5'd3, 1'b0, 32'h0, a0);
        tick(4);
        expect_wb("t2_r4", 5'd4, 32'h80000000);
        check("t2_flags", flags, 4'b0101);

        // 3: RAW stall, SUB waits for r5
        issue(OP_ADD, 5'd5, 5'd1, 5'd1, 1'b0, 32'h0, a0);
        issue(OP_SUB, 5'd6, 5'd5, 5'd1, 1'b0, 32'h0, a1);
        check("t3_spacing", a1 - a0, LAT + 2);
        check("t3_busA", busA, 32'h1E1E1E1E);
        check("t3_busB", busB, 32'h0F0F0F0F);
        tick(4);
        expect_wb("t3_r5", 5'd5, 32'h1E1E1E1E);
        expect_wb("t3_r6", 5'd6, 32'h0F0F0F0F);

        // 4: independent stream
        stream[0] = '{OP_OR,  5'd10, 5'd1, 5'd4, 1'b0, 32'h0, 32'h8F0F0F0F};
        stream[1] = '{OP_AND, 5'd11, 5'd2, 5'd1, 1'b0, 32'h0, 32'h0F0F0F0F};
        stream[2] = '{OP_XOR, 5'd12, 5'd1, 5'd2, 1'b0, 32'h0, 32'h70F0F0F0};
        stream[3] = '{OP_NOT, 5'd13, 5'd1, 5'd0, 1'b0, 32'h0, 32'hF0F0F0F0};
        stream[4] = '{OP_SL,  5'd14, 5'd3, 5'd0, 1'b1, 32'h4, 32'h00000010};
        stream[5] = '{OP_SR,  5'd15, 5'd4, 5'd3, 1'b0, 32'h0, 32'h40000000};
        stream[6] = '{OP_ADD, 5'd16, 5'd1, 5'd6, 1'b0, 32'h0, 32'h1E1E1E1E};
        stream[7] = '{OP_SUB, 5'd17, 5'd2, 5'd3, 1'b0, 32'h0, 32'h7FFFFFFE};
        wb_log.delete();
        for (int i = 0; i < 8; i++) begin
            issue(stream[i].op, stream[i].rd, stream[i].rs1, stream[i].rs2,
                  stream[i].ui, stream[i].imm, acc[i]);
        end
        tick(4);
        for (int i = 1; i < 8; i++) check("t4_issue_gap", acc[i] - acc[i-1], 1);
        check("t4_count", wb_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("t4_rd", (i < wb_log.size()) ? wb_log[i].rd : 'x, stream[i].rd);
            check("t4_data", (i < wb_log.size()) ? wb_log[i].data : 'x, stream[i].exp);
            if (i > 0)
                check("t4_wb_gap",
                      (i < wb_log.size()) ? wb_log[i].cyc - wb_log[i-1].cyc : 'x, 1);
        end
        check("t4_flags", flags, 4'h0);

        // 5: r0 destination and NOP opcode
        wb_log.delete();
        issue(OP_ADD, 5'd0, 5'd4, 5'd4, 1'b0, 32'h0, a0);
        tick(4);
        check("t5_r0_nowb", wb_log.size(), 0);
        check("t5_r0_flags", flags, 4'b1011);
        issue(5'h1F, 5'd20, 5'd4, 5'd4, 1'b0, 32'h0, a0);
        tick(4);
        check("t5_nop_nowb", wb_log.size(), 0);
        check("t5_nop_flags", flags, 4'b1011);
        issue(5'h1F, 5'd20, 5'd0, 5'd0, 1'b0, 32'h0, a0);
        issue(OP_LD, 5'd22, 5'd20, 5'd0, 1'b0, 32'h0, a1);
        check("t5_nop_nostall", a1 - a0, 1);
        tick(4);
        expect_wb("t5_r22", 5'd22, 32'h0);
        check("t5_ld_flags", flags, 4'b1000);

        // 6: reset with two ops in flight
        issue(OP_LD, 5'd7, 5'd0, 5'd0, 1'b1, 32'h5, a0);
        issue(OP_LD, 5'd8, 5'd0, 5'd0, 1'b1, 32'h6, a1);
        rst = 1'b1;
        wb_log.delete();
        #1;
        check("t6_ready_rst", in_ready, 0);
        tick(2);
        rst = 1'b0;
        #1;
        check("t6_ready_rel", in_ready, 1);
        check("t6_flags", flags, 4'h0);
        check("t6_busA", busA, 32'h0);
        tick(5);
        check("t6_nowb", wb_log.size(), 0);
        issue(OP_LD, 5'd9, 5'd1, 5'd0, 1'b0, 32'h0, a0);
        check("t6_r1_clr", busA, 32'h0);
        issue(OP_LD, 5'd10, 5'd4, 5'd0, 1'b0, 32'h0, a0);
        check("t6_r4_clr", busA, 32'h0);
        tick(4);
        expect_wb("t6_r9", 5'd9, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
